// File: rtl/noc2_msg_collector.sv
// noc2_msg_collector: receive-side endpoint for the L2 NoC2 flit stream.
// Reassembles one header flit plus up to 255 payload flits into a parallel
// message record. The record is presented on a valid/ready message port.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   noc2_valid_in     flit valid from the L2
//   noc2_data_in      64-bit flit from the L2
//   noc2_ready_in     collector accepts a flit this cycle (combinational in HOLD)
//   msg_valid         assembled message available
//   msg_ready         consumer accepts the message
//   msg_type/mshrid/len/dst_x/dst_y   header fields of the held message
//   msg_data          payload, first payload flit in [63:0]
//   msg_err           payload was longer than MAX_PAYLOAD and got truncated
//   msg_count         saturating count of messages handed off since reset
module noc2_msg_collector #(
    parameter int unsigned MAX_PAYLOAD = 3,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        noc2_valid_in,
    input  logic [63:0]                 noc2_data_in,
    output logic                        noc2_ready_in,
    output logic                        msg_valid,
    input  logic                        msg_ready,
    output logic [7:0]                  msg_type,
    output logic [7:0]                  msg_mshrid,
    output logic [7:0]                  msg_len,
    output logic [7:0]                  msg_dst_x,
    output logic [7:0]                  msg_dst_y,
    output logic [64*MAX_PAYLOAD-1:0]   msg_data,
    output logic                        msg_err,
    output logic [CNT_W-1:0]            msg_count
);

    localparam int unsigned FLIT_W = 64;
    localparam int unsigned DATA_W = FLIT_W * MAX_PAYLOAD;
    localparam int unsigned IDX_W  = 8;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_PAY  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [7:0]          type_q, type_d;
    logic [7:0]          mshrid_q, mshrid_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          dst_x_q, dst_x_d;
    logic [7:0]          dst_y_q, dst_y_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                err_q, err_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic                flit_xfer;
    logic                handoff;
    logic                take_hdr;
    logic [7:0]          hdr_len;

    // In HOLD a new header may only enter in the cycle the held message leaves.
    assign noc2_ready_in = (state_q == ST_HOLD) ? msg_ready : 1'b1;
    assign flit_xfer     = noc2_valid_in && noc2_ready_in;
    assign handoff       = (state_q == ST_HOLD) && msg_ready;
    assign take_hdr      = flit_xfer && (state_q != ST_PAY);
    assign hdr_len       = noc2_data_in[29:22];

    // Next-state and record update.
    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        mshrid_d = mshrid_q;
        len_d    = len_q;
        dst_x_d  = dst_x_q;
        dst_y_d  = dst_y_q;
        data_d   = data_q;
        err_d    = err_q;
        idx_d    = idx_q;
        count_d  = count_q;

        case (state_q)
            ST_PAY: begin
                if (flit_xfer) begin
                    if (idx_q < IDX_W'(MAX_PAYLOAD)) begin
                        for (int unsigned s = 0; s < MAX_PAYLOAD; s++) begin
                            if (idx_q == IDX_W'(s)) begin
                                data_d[FLIT_W*s +: FLIT_W] = noc2_data_in;
                            end
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                    idx_d = idx_q + IDX_W'(1);
                    // len_q >= 1 whenever PAY is entered, so len_q-1 cannot wrap.
                    if (idx_q == IDX_W'(len_q - 8'd1)) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (handoff) begin
                    if (count_q != {CNT_W{1'b1}}) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    state_d = ST_HDR;
                end
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase

        // Header capture, shared by HDR and the HOLD back-to-back case.
        if (take_hdr) begin
            type_d   = noc2_data_in[21:14];
            mshrid_d = noc2_data_in[13:6];
            len_d    = hdr_len;
            dst_x_d  = noc2_data_in[49:42];
            dst_y_d  = noc2_data_in[41:34];
            data_d   = '0;
            err_d    = 1'b0;
            idx_d    = '0;
            state_d  = (hdr_len == 8'd0) ? ST_HOLD : ST_PAY;
        end
    end

    // State and record registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_HDR;
            type_q   <= '0;
            mshrid_q <= '0;
            len_q    <= '0;
            dst_x_q  <= '0;
            dst_y_q  <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
            idx_q    <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            type_q   <= type_d;
            mshrid_q <= mshrid_d;
            len_q    <= len_d;
            dst_x_q  <= dst_x_d;
            dst_y_q  <= dst_y_d;
            data_q   <= data_d;
            err_q    <= err_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
        end
    end

    assign msg_valid  = (state_q == ST_HOLD);
    assign msg_type   = type_q;
    assign msg_mshrid = mshrid_q;
    assign msg_len    = len_q;
    assign msg_dst_x  = dst_x_q;
    assign msg_dst_y  = dst_y_q;
    assign msg_data   = data_q;
    assign msg_err    = err_q;
    assign msg_count  = count_q;

endmodule

// File: tb/tb_noc2_msg_collector.sv
// Bench for noc2_msg_collector: drivers issue messages and push the expected
// record into a queue; a negedge monitor pops and compares on every handoff.
module tb_noc2_msg_collector;

    localparam int unsigned MAXP = 3;
    localparam int unsigned CW   = 4;
    localparam int unsigned DW   = 64 * MAXP;
    localparam int unsigned MAXC = (1 << CW) - 1;

    logic            clk;
    logic            rst_n;
    logic            noc2_valid_in;
    logic [63:0]     noc2_data_in;
    logic            noc2_ready_in;
    logic            msg_valid;
    logic            msg_ready;
    logic [7:0]      msg_type;
    logic [7:0]      msg_mshrid;
    logic [7:0]      msg_len;
    logic [7:0]      msg_dst_x;
    logic [7:0]      msg_dst_y;
    logic [DW-1:0]   msg_data;
    logic            msg_err;
    logic [CW-1:0]   msg_count;

    noc2_msg_collector #(.MAX_PAYLOAD(MAXP), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .noc2_valid_in (noc2_valid_in),
        .noc2_data_in  (noc2_data_in),
        .noc2_ready_in (noc2_ready_in),
        .msg_valid     (msg_valid),
        .msg_ready     (msg_ready),
        .msg_type      (msg_type),
        .msg_mshrid    (msg_mshrid),
        .msg_len       (msg_len),
        .msg_dst_x     (msg_dst_x),
        .msg_dst_y     (msg_dst_y),
        .msg_data      (msg_data),
        .msg_err       (msg_err),
        .msg_count     (msg_count)
    );

    typedef struct {
        logic [7:0]    typ;
        logic [7:0]    mshr;
        logic [7:0]    len;
        logic [7:0]    dx;
        logic [7:0]    dy;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   rdy_mode   = 0;   // 0: hold low, 1: hold high, 2: random
    int   n_hand     = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Consumer ready, updated after the driver so both settle before the negedge.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       msg_ready = 1'b0;
            1:       msg_ready = 1'b1;
            default: msg_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: a message is handed off at the next posedge when valid&&ready here.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                n_hand = 0;
            end else begin
                chk("msg_count", 256'(msg_count), 256'((n_hand > int'(MAXC)) ? MAXC : n_hand));
                if (msg_valid) chk("ready_in_hold", 256'(noc2_ready_in), 256'(msg_ready));
                else           chk("ready_in_idle", 256'(noc2_ready_in), 256'(1));
                if (msg_valid && msg_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_msg", 256'(1), 256'(0));
                    end else begin
                        e = exp_q.pop_front();
                        chk("msg_type",   256'(msg_type),   256'(e.typ));
                        chk("msg_mshrid", 256'(msg_mshrid), 256'(e.mshr));
                        chk("msg_len",    256'(msg_len),    256'(e.len));
                        chk("msg_dst_x",  256'(msg_dst_x),  256'(e.dx));
                        chk("msg_dst_y",  256'(msg_dst_y),  256'(e.dy));
                        chk("msg_data",   256'(msg_data),   256'(e.data));
                        chk("msg_err",    256'(msg_err),    256'(e.err));
                    end
                    n_hand++;
                end
            end
        end
    end

    task automatic idle_cycle();
        noc2_valid_in = 1'b0;
        noc2_data_in  = {$urandom, $urandom};
        @(posedge clk);
        #1;
    endtask

    // Present one flit and hold it until it is accepted; returns stall cycles.
    task automatic put_flit(input logic [63:0] d, output int stalls);
        stalls = 0;
        noc2_valid_in = 1'b1;
        noc2_data_in  = d;
        forever begin
            @(negedge clk);
            if (noc2_ready_in) break;
            @(posedge clk);
            #1;
            stalls++;
            if (stalls > 2000) begin
                chk("flit_accept_timeout", 256'(0), 256'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        noc2_valid_in = 1'b0;
        noc2_data_in  = {$urandom, $urandom};
    endtask

    function automatic logic [63:0] make_hdr(input logic [7:0] typ, input logic [7:0] mshr,
                                             input logic [7:0] len, input logic [7:0] dx,
                                             input logic [7:0] dy);
        logic [63:0] h;
        h = {$urandom, $urandom};
        h[29:22] = len;
        h[21:14] = typ;
        h[13:6]  = mshr;
        h[49:42] = dx;
        h[41:34] = dy;
        return h;
    endfunction

    // Issue a full message: the expected record follows from the length rule alone.
    task automatic send_msg(input logic [7:0] typ, input logic [7:0] mshr, input int len,
                            input int gap_max, output int stalls_tot, output exp_t e);
        logic [63:0] p;
        int st;
        e.typ  = typ;
        e.mshr = mshr;
        e.len  = 8'(len);
        e.dx   = 8'($urandom);
        e.dy   = 8'($urandom);
        e.data = '0;
        e.err  = (len > int'(MAXP));
        stalls_tot = 0;
        exp_q.push_back(e);
        repeat ($urandom_range(0, gap_max)) idle_cycle();
        put_flit(make_hdr(typ, mshr, 8'(len), e.dx, e.dy), st);
        stalls_tot += st;
        for (int i = 0; i < len; i++) begin
            p = {$urandom, $urandom};
            if (i < int'(MAXP)) e.data[64*i +: 64] = p;
            if (i == int'(MAXP) - 1 || i == len - 1) exp_q[exp_q.size()-1].data = e.data;
            repeat ($urandom_range(0, gap_max)) idle_cycle();
            put_flit(p, st);
            stalls_tot += st;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 || msg_valid) begin
            @(posedge clk);
            #1;
            n++;
            if (n > 2000) begin
                chk("drain_timeout", 256'(0), 256'(1));
                break;
            end
        end
    endtask

    initial begin
        exp_t e;
        int   st;
        int   st2;
        logic [63:0] junk;

        rst_n         = 1'b0;
        noc2_valid_in = 1'b0;
        noc2_data_in  = '0;
        msg_ready     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_valid", 256'(msg_valid), 256'(0));
        chk("reset_ready", 256'(noc2_ready_in), 256'(1));
        chk("reset_data",  256'(msg_data), 256'(0));
        chk("reset_count", 256'(msg_count), 256'(0));
        @(posedge clk);
        #1;

        // Two-payload message held by the consumer.
        rdy_mode = 0;
        send_msg(8'h0B, 8'h05, 2, 0, st, e);
        @(negedge clk);
        chk("t1_valid_after_B", 256'(msg_valid), 256'(1));
        chk("t1_ready_held",    256'(noc2_ready_in), 256'(0));
        chk("t1_slice0",        256'(msg_data[63:0]),    256'(e.data[63:0]));
        chk("t1_slice1",        256'(msg_data[127:64]),  256'(e.data[127:64]));
        chk("t1_slice2_zero",   256'(msg_data[191:128]), 256'(0));
        chk("t1_type",          256'(msg_type), 256'(8'h0B));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t1_still_valid",   256'(msg_valid), 256'(1));
        @(posedge clk);
        #1;
        rdy_mode = 1;
        wait_drain();

        // Zero-length message with the consumer always ready.
        send_msg(8'h0D, 8'h11, 0, 0, st, e);
        @(negedge clk);
        chk("t2_valid_cycle1", 256'(msg_valid), 256'(1));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t2_valid_cycle2", 256'(msg_valid), 256'(0));
        @(posedge clk);
        #1;

        // Over-long message truncates; the next one clears the error.
        send_msg(8'h21, 8'h22, 5, 0, st, e);
        chk("t3_no_stall", 256'(st), 256'(0));
        send_msg(8'h23, 8'h24, 1, 0, st, e);
        wait_drain();

        // Back-to-back single-payload messages: four flits, no stalls.
        send_msg(8'h31, 8'h01, 1, 0, st, e);
        send_msg(8'h32, 8'h02, 1, 0, st2, e);
        chk("t4_no_stall", 256'(st + st2), 256'(0));
        wait_drain();

        // Random traffic with random consumer back-pressure.
        rdy_mode = 2;
        for (int m = 0; m < 40; m++) begin
            send_msg(8'($urandom), 8'($urandom), $urandom_range(0, 6), 2, st, e);
        end
        rdy_mode = 1;
        wait_drain();

        // Reset in the middle of a message.
        put_flit(make_hdr(8'h44, 8'h45, 8'd3, 8'h46, 8'h47), st);
        junk = {$urandom, $urandom};
        put_flit(junk, st);
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 256'(msg_valid), 256'(0));
        chk("rst_len",   256'(msg_len),   256'(0));
        chk("rst_type",  256'(msg_type),  256'(0));
        chk("rst_data",  256'(msg_data),  256'(0));
        chk("rst_count", 256'(msg_count), 256'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_msg(8'h51, 8'h52, 2, 0, st, e);
        wait_drain();

        // Counter saturation with a 4-bit counter.
        for (int m = 0; m < int'(MAXC) + 4; m++) begin
            send_msg(8'h60, 8'(m), 0, 0, st, e);
        end
        wait_drain();
        @(negedge clk);
        chk("count_saturated", 256'(msg_count), 256'(MAXC));
        chk("queue_empty", 256'(exp_q.size()), 256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
